// File: rtl/dmem_mp_if.sv
// dmem_mp_if: per-port request/response bundle for the multi-port data memory.
//   master: drives Req, WE, Addr, WData, BE; observes Ready, RValid, RData, Err
//   slave : the memory side of the same signals
// Fields are packed per port: port p at Addr/WData/RData[32p+31:32p], BE[4p+3:4p].
interface dmem_mp_if #(
  parameter int unsigned NPORTS = 2
);
  logic [NPORTS-1:0]    Req;
  logic [NPORTS-1:0]    WE;
  logic [NPORTS*32-1:0] Addr;
  logic [NPORTS*32-1:0] WData;
  logic [NPORTS*4-1:0]  BE;
  logic                 Ready;
  logic [NPORTS-1:0]    RValid;
  logic [NPORTS*32-1:0] RData;
  logic [NPORTS-1:0]    Err;

  modport master (
    output Req, WE, Addr, WData, BE,
    input  Ready, RValid, RData, Err
  );

  modport slave (
    input  Req, WE, Addr, WData, BE,
    output Ready, RValid, RData, Err
  );
endinterface

// File: rtl/dmem_mp.sv
// dmem_mp: multi-port 32-bit word memory shared by NPORTS cores.
//   CLK  : clock, rising edge
//   RST  : asynchronous active-low reset; restarts the array clear sequence
//   bus  : dmem_mp_if slave port (per-port Req/WE/Addr/WData/BE in,
//          Ready/RValid/RData/Err out)
// After reset the array is cleared one word per cycle; Ready rises after DEPTH
// cycles. Accesses are read-first with a fixed 1-cycle response; concurrent
// writes to one word resolve per byte lane, lowest-numbered port wins.
module dmem_mp #(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned DEPTH  = 128
) (
  input logic        CLK,
  input logic        RST,
  dmem_mp_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [NPORTS-1:0]    rvalid_q, rvalid_d;
  logic [NPORTS-1:0]    err_q, err_d;
  logic [NPORTS*DW-1:0] rdata_q, rdata_d;

  logic [DW-1:0]        mem_q [DEPTH];

  logic [NPORTS-1:0]    acc_c;
  logic [NPORTS-1:0]    inr_c;
  logic [AW-1:0]        idx_c [NPORTS];

  // Per-port accept, range check on the full word address, and word index
  always_comb begin
    for (int p = 0; p < int'(NPORTS); p++) begin
      acc_c[p] = bus.Req[p] && ready_q;
      inr_c[p] = 32'(bus.Addr[DW*p+2 +: 30]) < 32'(DEPTH);
      idx_c[p] = bus.Addr[DW*p+2 +: AW];
    end
  end

  // Clear sequencer: INIT walks every word once, then RUN until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
        cnt_d   = '0;
      end
    end else begin
      ready_d = 1'b1;
    end
  end

  // Responses: pre-edge word contents, zero with Err when out of range;
  // RData/Err hold when a port is idle
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    for (int p = 0; p < int'(NPORTS); p++) begin
      if (acc_c[p]) begin
        rvalid_d[p]         = 1'b1;
        err_d[p]            = !inr_c[p];
        rdata_d[DW*p +: DW] = inr_c[p] ? mem_q[idx_c[p]] : '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Word array; ports visited high to low so the lowest port's lane lands last
  always_ff @(posedge CLK) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int p = int'(NPORTS) - 1; p >= 0; p--) begin
        if (acc_c[p] && bus.WE[p] && inr_c[p]) begin
          for (int b = 0; b < int'(BW); b++) begin
            if (bus.BE[BW*p+b]) begin
              mem_q[idx_c[p]][8*b +: 8] <= bus.WData[DW*p+8*b +: 8];
            end
          end
        end
      end
    end
  end

  assign bus.Ready  = ready_q;
  assign bus.RValid = rvalid_q;
  assign bus.RData  = rdata_q;
  assign bus.Err    = err_q;

endmodule

// File: tb/tb_dmem_mp.sv
// tb_dmem_mp: self-checking bench for dmem_mp (2 ports, 128 words).
// Expected responses are queued per port when a request is driven and popped
// one cycle later when the DUT responds.
module tb_dmem_mp;

  localparam int unsigned NP    = 2;
  localparam int unsigned DEPTH = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dmem_mp_if #(.NPORTS(NP)) bus ();

  dmem_mp #(.NPORTS(NP), .DEPTH(DEPTH)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } op_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    int  port;
    op_t op;
  } vec_t;

  localparam op_t IDLE = '0;

  rsp_t exp_q [NP][$];
  vec_t vecs [$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic op_t rd(input logic [31:0] a, input logic [31:0] e,
                             input logic err = 1'b0);
    op_t o;
    o = '0;
    o.req = 1'b1; o.addr = a; o.exp_rdata = e; o.exp_err = err;
    return o;
  endfunction

  function automatic op_t wr(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic [31:0] e,
                             input logic err = 1'b0);
    op_t o;
    o = rd(a, e, err);
    o.we = 1'b1; o.wdata = d; o.be = be;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests, then compare responses against the queue
  task automatic tick(input op_t o0, input op_t o1, input bit rdy);
    op_t o [NP];
    o[0] = o0;
    o[1] = o1;
    for (int p = 0; p < int'(NP); p++) begin
      bus.Req[p]           = o[p].req;
      bus.WE[p]            = o[p].we;
      bus.Addr[32*p +: 32] = o[p].addr;
      bus.WData[32*p +: 32] = o[p].wdata;
      bus.BE[4*p +: 4]     = o[p].be;
      if (rdy && o[p].req) exp_q[p].push_back('{o[p].exp_rdata, o[p].exp_err});
    end
    @(posedge clk);
    #1;
    bus.Req = '0;
    for (int p = 0; p < int'(NP); p++) begin
      if (exp_q[p].size() > 0) begin
        rsp_t r;
        r = exp_q[p].pop_front();
        chk($sformatf("rvalid%0d", p), 32'(bus.RValid[p]), 32'd1);
        chk($sformatf("rdata%0d@%h", p, o[p].addr), bus.RData[32*p +: 32], r.rdata);
        chk($sformatf("err%0d@%h", p, o[p].addr), 32'(bus.Err[p]), 32'(r.err));
      end else begin
        chk($sformatf("idle_rvalid%0d", p), 32'(bus.RValid[p]), 32'd0);
      end
    end
  endtask

  // Count cycles from reset release to Ready; a write attempted during INIT must be ignored
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (bus.Ready !== 1'b1 && n < 400) begin
      tick((n == 5) ? wr(32'h0, 32'hFFFF_FFFF, 4'hF, 32'h0) : IDLE, IDLE, 1'b0);
      n++;
    end
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    bus.Req   = '0;
    bus.WE    = '0;
    bus.Addr  = '0;
    bus.WData = '0;
    bus.BE    = '0;

    vecs.push_back('{0, wr(32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0)});
    vecs.push_back('{1, rd(32'h10, 32'hDEAD_BEEF)});
    vecs.push_back('{0, wr(32'h14, 32'h1122_3344, 4'hF, 32'h0)});
    vecs.push_back('{0, wr(32'h14, 32'hAABB_CCDD, 4'b0101, 32'h1122_3344)});
    vecs.push_back('{1, rd(32'h14, 32'h11BB_33DD)});
    vecs.push_back('{0, wr(32'h17, 32'h0, 4'b0000, 32'h11BB_33DD)});
    vecs.push_back('{1, rd(32'h16, 32'h11BB_33DD)});
    vecs.push_back('{1, rd(32'h200, 32'h0, 1'b1)});
    vecs.push_back('{1, wr(32'h200, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1)});
    vecs.push_back('{0, rd(32'h0, 32'h0)});
    vecs.push_back('{0, rd(32'h1FC, 32'h0)});
    vecs.push_back('{0, wr(32'h1FC, 32'hCAFE_F00D, 4'hF, 32'h0)});
    vecs.push_back('{0, rd(32'h1FC, 32'hCAFE_F00D)});
    vecs.push_back('{0, rd(32'h8000_0010, 32'h0, 1'b1)});
    vecs.push_back('{0, rd(32'h10, 32'hDEAD_BEEF)});

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.Ready), 32'd0);
    chk("rst_rvalid", 32'(bus.RValid), 32'd0);
    chk("rst_rdata", bus.RData[63:32] | bus.RData[31:0], 32'd0);
    chk("rst_err", 32'(bus.Err), 32'd0);
    rst_n = 1'b1;
    wait_ready("ready_latency");

    // Every word reads back zero after the clear sequence
    for (int i = 0; i < int'(DEPTH); i++) begin
      tick(rd(32'(i * 4), 32'h0), rd(32'((int'(DEPTH) - 1 - i) * 4), 32'h0), 1'b1);
    end

    foreach (vecs[i]) begin
      if (vecs[i].port == 0) tick(vecs[i].op, IDLE, 1'b1);
      else                   tick(IDLE, vecs[i].op, 1'b1);
    end

    // Same-cycle write conflict, per-lane lowest-port priority
    tick(wr(32'h20, 32'h0000_FFFF, 4'b0011, 32'h0),
         wr(32'h20, 32'h1234_5678, 4'b1111, 32'h0), 1'b1);
    tick(rd(32'h20, 32'h1234_FFFF), IDLE, 1'b1);

    // Read-first against another port's same-cycle write
    tick(wr(32'h30, 32'h9, 4'hF, 32'h0), IDLE, 1'b1);
    tick(wr(32'h30, 32'h5, 4'hF, 32'h9), rd(32'h30, 32'h9), 1'b1);
    tick(IDLE, rd(32'h30, 32'h5), 1'b1);

    // RData/Err hold while idle
    tick(IDLE, rd(32'h200, 32'h0, 1'b1), 1'b1);
    tick(IDLE, IDLE, 1'b1);
    chk("hold_err1", 32'(bus.Err[1]), 32'd1);
    chk("hold_rdata1_err", bus.RData[63:32], 32'h0);
    tick(IDLE, rd(32'h10, 32'hDEAD_BEEF), 1'b1);
    tick(IDLE, IDLE, 1'b1);
    chk("hold_rdata1", bus.RData[63:32], 32'hDEAD_BEEF);
    chk("hold_err1_clr", 32'(bus.Err[1]), 32'd0);

    // Asynchronous reset mid-RUN
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(bus.Ready), 32'd0);
    chk("async_rst_rdata", bus.RData[63:32] | bus.RData[31:0], 32'd0);
    chk("async_rst_err", 32'(bus.Err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset pulse mid-INIT restarts the clear from word 0
    for (int i = 0; i < 50; i++) tick(IDLE, IDLE, 1'b0);
    chk("mid_init_not_ready", 32'(bus.Ready), 32'd0);
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("ready_latency_after_pulse");
    tick(rd(32'h10, 32'h0), rd(32'h1FC, 32'h0), 1'b1);
    tick(rd(32'h20, 32'h0), rd(32'h14, 32'h0), 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
